mem_port_arbiter: RTL and testbench

Shares the single-port unified memory between the IF stage (instruction fetch) and the MEM stage (lw/sw) of the pipelined core. It sequences one memory transaction at a time with a request/ack handshake and latches each result until the pipeline advances. It produces per-stage stall outputs, which top-level OR-s with the hazard unit's IF/ID and ID/EX stalls.

---
 rtl/mem_port_arbiter_pkg.sv | 20 ++
 rtl/mem_arb_hold_reg.sv | 39 +++
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared definitions for the IF/MEM memory port arbiter.
//   - arb_state_e     : arbiter FSM state encoding
//   - ADDR_W_DEF      : default address width
//   - DATA_W_DEF      : default data width
//   - TIMEOUT_POISON  : value returned to a stage whose access timed out
//                       (only used when MEM_ARB_TIMEOUT_EN is defined)
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_DACC = 2'd1,
        ARB_IACC = 2'd2
    } arb_state_e;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    localparam logic [31:0] TIMEOUT_POISON = 32'hDEADDEAD;

endpackage

// File: rtl/mem_arb_hold_reg.sv
// mem_arb_hold_reg: result register plus valid flag for one pipeline stage.
// The flag sets when an access completes and clears when the pipeline advances;
// a completion in the same cycle as an advance wins.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   set        : access completed for this stage this cycle
//   load       : capture din along with set (low for stores)
//   clr        : pipeline advance, consumes the held result
//   din        : result data
//   dout       : held result
//   vld        : held result is valid
module mem_arb_hold_reg #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set,
    input  logic              load,
    input  logic              clr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              vld
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout <= '0;
            vld  <= 1'b0;
        end else if (set) begin
            vld <= 1'b1;
            if (load) begin
                dout <= din;
            end
        end else if (clr) begin
            vld <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a single-port memory between the IF and MEM stages.
// One transaction at a time over a req/ack handshake; results are held until
// pipeAdv. The MEM stage has priority because it holds the older instruction.
// Optional feature macro: MEM_ARB_TIMEOUT_EN (watchdog that poisons and
// releases a stage whose access never acks; sets sticky timeout_err).
// Ports:
//   clk, reset                      : clock, asynchronous active-high reset
//   fetchReq_IF, pc_IF              : fetch request and address
//   instr_IF, stall_IF              : held instruction, IF stall
//   memRead_MEM, memWrite_MEM       : lw / sw in MEM
//   addr_MEM, wdata_MEM             : data address and store data
//   rdata_MEM, stall_MEM            : held load data, MEM stall
//   pipeAdv                         : pipeline advance, consumes held results
//   mem_req/we/addr/wdata           : registered memory request
//   mem_rdata, mem_ack              : memory response
//   timeout_err                     : sticky watchdog error (0 without feature)
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetchReq_IF,
    input  logic [ADDR_W-1:0] pc_IF,
    output logic [DATA_W-1:0] instr_IF,
    output logic              stall_IF,
    input  logic              memRead_MEM,
    input  logic              memWrite_MEM,
    input  logic [ADDR_W-1:0] addr_MEM,
    input  logic [DATA_W-1:0] wdata_MEM,
    output logic [DATA_W-1:0] rdata_MEM,
    output logic              stall_MEM,
    input  logic              pipeAdv,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              timeout_err
);

    arb_state_e        state_q, state_d;
    logic              req_d, we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;

    logic instr_vld, data_vld;
    logic d_pend, i_pend;
    logic in_access, tmo_fire, finish, d_done, i_done;
    logic [DATA_W-1:0] result;

    always_comb begin
        d_pend    = (memRead_MEM | memWrite_MEM) & ~data_vld;
        i_pend    = fetchReq_IF & ~instr_vld;
        stall_MEM = d_pend;
        stall_IF  = i_pend | d_pend;
        in_access = (state_q == ARB_DACC) || (state_q == ARB_IACC);
        finish    = in_access & (mem_ack | tmo_fire);
        d_done    = finish & (state_q == ARB_DACC);
        i_done    = finish & (state_q == ARB_IACC);
        result    = mem_ack ? mem_rdata : DATA_W'(TIMEOUT_POISON);
    end

    // Grant in IDLE or in the completion cycle. The stage being completed is
    // masked out since its vld only becomes visible next cycle.
    always_comb begin
        state_d = state_q;
        req_d   = mem_req;
        we_d    = mem_we;
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
        if ((state_q == ARB_IDLE) || finish) begin
            if (d_pend && !d_done) begin
                state_d = ARB_DACC;
                req_d   = 1'b1;
                we_d    = memWrite_MEM;
                addr_d  = addr_MEM;
                wdata_d = wdata_MEM;
            end else if (i_pend && !i_done) begin
                state_d = ARB_IACC;
                req_d   = 1'b1;
                we_d    = 1'b0;
                addr_d  = pc_IF;
            end else begin
                state_d = ARB_IDLE;
                req_d   = 1'b0;
                we_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ARB_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state_q   <= state_d;
            mem_req   <= req_d;
            mem_we    <= we_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
        end
    end

    // A squashed request still completes but leaves vld clear.
    mem_arb_hold_reg #(
        .DATA_W (DATA_W)
    ) u_data_hold (
        .clk   (clk),
        .reset (reset),
        .set   (d_done & (memRead_MEM | memWrite_MEM)),
        .load  (tmo_fire | ~mem_we),
        .clr   (pipeAdv),
        .din   (result),
        .dout  (rdata_MEM),
        .vld   (data_vld)
    );

    mem_arb_hold_reg #(
        .DATA_W (DATA_W)
    ) u_instr_hold (
        .clk   (clk),
        .reset (reset),
        .set   (i_done & fetchReq_IF),
        .load  (1'b1),
        .clr   (pipeAdv),
        .din   (result),
        .dout  (instr_IF),
        .vld   (instr_vld)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q;

    assign tmo_fire    = in_access & ~mem_ack & (cnt_q == CNT_LIMIT);
    assign timeout_err = err_q;

    // Counts cycles spent in the current access; a grant restarts it.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if ((state_q == ARB_IDLE) || finish) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (tmo_fire) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign tmo_fire    = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetchReq_IF;
    logic [31:0] pc_IF;
    logic [31:0] instr_IF;
    logic        stall_IF;
    logic        memRead_MEM;
    logic        memWrite_MEM;
    logic [31:0] addr_MEM;
    logic [31:0] wdata_MEM;
    logic [31:0] rdata_MEM;
    logic        stall_MEM;
    logic        pipeAdv;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        timeout_err;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .fetchReq_IF  (fetchReq_IF),
        .pc_IF        (pc_IF),
        .instr_IF     (instr_IF),
        .stall_IF     (stall_IF),
        .memRead_MEM  (memRead_MEM),
        .memWrite_MEM (memWrite_MEM),
        .addr_MEM     (addr_MEM),
        .wdata_MEM    (wdata_MEM),
        .rdata_MEM    (rdata_MEM),
        .stall_MEM    (stall_MEM),
        .pipeAdv      (pipeAdv),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .timeout_err  (timeout_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        fetchReq_IF = 0; pc_IF = 0; memRead_MEM = 0; memWrite_MEM = 0;
        addr_MEM = 0; wdata_MEM = 0; pipeAdv = 0; mem_rdata = 0; mem_ack = 0;
        #2;
        vec_cnt++;
        if ({mem_req, mem_we, stall_IF, stall_MEM, timeout_err} !== 5'b0) begin
            err_cnt++;
            $display("FAIL reset_ctrl got %b want 00000",
                     {mem_req, mem_we, stall_IF, stall_MEM, timeout_err});
        end
        vec_cnt++;
        if ({mem_addr, mem_wdata, instr_IF, rdata_MEM} !== 128'h0) begin
            err_cnt++;
            $display("FAIL reset_data got %h %h %h %h want zeros",
                     mem_addr, mem_wdata, instr_IF, rdata_MEM);
        end
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        fetchReq_IF = 1; pc_IF = 32'h40;
        #1;
        vec_cnt++;
        if (stall_IF !== 1'b1 || mem_req !== 1'b0) begin
            err_cnt++;
            $display("FAIL fetch_c0 stall_IF=%b mem_req=%b want 1 0", stall_IF, mem_req);
        end
        tick();
        vec_cnt++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h40 || stall_IF !== 1'b1) begin
            err_cnt++;
            $display("FAIL fetch_req req=%b we=%b addr=%h stall=%b want 1 0 40 1",
                     mem_req, mem_we, mem_addr, stall_IF);
        end
        tick();
        tick();
        mem_ack = 1; mem_rdata = 32'h8C010004;
        #1;
        vec_cnt++;
        if (stall_IF !== 1'b1) begin
            err_cnt++;
            $display("FAIL fetch_ack_cycle stall_IF=%b want 1", stall_IF);
        end
        tick();
        mem_ack = 0; mem_rdata = 0;
        #1;
        vec_cnt++;
        if (stall_IF !== 1'b0 || instr_IF !== 32'h8C010004 || mem_req !== 1'b0) begin
            err_cnt++;
            $display("FAIL fetch_done stall=%b instr=%h req=%b want 0 8c010004 0",
                     stall_IF, instr_IF, mem_req);
        end
        pipeAdv = 1;
        tick();
        pipeAdv = 0;
        #1;
        vec_cnt++;
        if (stall_IF !== 1'b1 || mem_req !== 1'b0 || instr_IF !== 32'h8C010004) begin
            err_cnt++;
            $display("FAIL fetch_pipeadv stall=%b req=%b instr=%h want 1 0 8c010004",
                     stall_IF, mem_req, instr_IF);
        end
        fetchReq_IF = 0;
        tick();
    endtask

    task automatic test_contention();
        fetchReq_IF = 1; pc_IF = 32'h44; memRead_MEM = 1; addr_MEM = 32'h100;
        #1;
        vec_cnt++;
        if (stall_MEM !== 1'b1 || stall_IF !== 1'b1) begin
            err_cnt++;
            $display("FAIL cont_stalls mem=%b if=%b want 1 1", stall_MEM, stall_IF);
        end
        tick();
        vec_cnt++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0) begin
            err_cnt++;
            $display("FAIL cont_first req=%b addr=%h we=%b want 1 100 0",
                     mem_req, mem_addr, mem_we);
        end
        mem_ack = 1; mem_rdata = 32'hAAAA5555;
        tick();
        mem_ack = 0;
        #1;
        vec_cnt++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h44 || stall_MEM !== 1'b0 ||
            stall_IF !== 1'b1 || rdata_MEM !== 32'hAAAA5555) begin
            err_cnt++;
            $display("FAIL cont_second req=%b addr=%h smem=%b sif=%b rdata=%h want 1 44 0 1 aaaa5555",
                     mem_req, mem_addr, stall_MEM, stall_IF, rdata_MEM);
        end
        mem_ack = 1; mem_rdata = 32'h11112222;
        tick();
        mem_ack = 0; mem_rdata = 0;
        #1;
        vec_cnt++;
        if (stall_IF !== 1'b0 || instr_IF !== 32'h11112222 || mem_req !== 1'b0) begin
            err_cnt++;
            $display("FAIL cont_done sif=%b instr=%h req=%b want 0 11112222 0",
                     stall_IF, instr_IF, mem_req);
        end
        fetchReq_IF = 0; memRead_MEM = 0; pipeAdv = 1;
        tick();
        pipeAdv = 0;
    endtask

    task automatic test_store();
        memWrite_MEM = 1; addr_MEM = 32'h200; wdata_MEM = 32'h12345678;
        tick();
        addr_MEM = 32'h999; wdata_MEM = 32'hCAFEBABE;
        vec_cnt++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h200 ||
            mem_wdata !== 32'h12345678) begin
            err_cnt++;
            $display("FAIL store_req req=%b we=%b addr=%h wdata=%h want 1 1 200 12345678",
                     mem_req, mem_we, mem_addr, mem_wdata);
        end
        tick();
        vec_cnt++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h200 ||
            mem_wdata !== 32'h12345678) begin
            err_cnt++;
            $display("FAIL store_hold req=%b we=%b addr=%h wdata=%h want 1 1 200 12345678",
                     mem_req, mem_we, mem_addr, mem_wdata);
        end
        mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
        tick();
        mem_ack = 0; mem_rdata = 0;
        #1;
        vec_cnt++;
        if (rdata_MEM !== 32'hAAAA5555 || stall_MEM !== 1'b0 || mem_req !== 1'b0) begin
            err_cnt++;
            $display("FAIL store_done rdata=%h smem=%b req=%b want aaaa5555 0 0",
                     rdata_MEM, stall_MEM, mem_req);
        end
        memWrite_MEM = 0; pipeAdv = 1;
        tick();
        pipeAdv = 0;
    endtask

    task automatic test_squash();
        fetchReq_IF = 1; pc_IF = 32'h80;
        tick();
        vec_cnt++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h80) begin
            err_cnt++;
            $display("FAIL squash_req req=%b addr=%h want 1 80", mem_req, mem_addr);
        end
        fetchReq_IF = 0;
        tick();
        vec_cnt++;
        if (mem_req !== 1'b1) begin
            err_cnt++;
            $display("FAIL squash_inflight req=%b want 1", mem_req);
        end
        mem_ack = 1; mem_rdata = 32'h5A5A5A5A;
        tick();
        mem_ack = 0; mem_rdata = 0;
        #1;
        vec_cnt++;
        if (mem_req !== 1'b0 || instr_IF !== 32'h11112222) begin
            err_cnt++;
            $display("FAIL squash_done req=%b instr=%h want 0 11112222", mem_req, instr_IF);
        end
        fetchReq_IF = 1;
        #1;
        vec_cnt++;
        if (stall_IF !== 1'b1) begin
            err_cnt++;
            $display("FAIL squash_vld stall_IF=%b want 1 (vld must stay clear)", stall_IF);
        end
        fetchReq_IF = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        memRead_MEM = 1; addr_MEM = 32'h300;
        tick();
        vec_cnt++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin
            err_cnt++;
            $display("FAIL rstmid_req req=%b addr=%h want 1 300", mem_req, mem_addr);
        end
        #2;
        reset = 1;
        #1;
        vec_cnt++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h0 || rdata_MEM !== 32'h0) begin
            err_cnt++;
            $display("FAIL rstmid_drop req=%b addr=%h rdata=%h want 0 0 0",
                     mem_req, mem_addr, rdata_MEM);
        end
        tick();
        reset = 0;
        #1;
        vec_cnt++;
        if (mem_req !== 1'b0 || stall_MEM !== 1'b1) begin
            err_cnt++;
            $display("FAIL rstmid_idle req=%b smem=%b want 0 1", mem_req, stall_MEM);
        end
        tick();
        vec_cnt++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin
            err_cnt++;
            $display("FAIL rstmid_restart req=%b addr=%h want 1 300", mem_req, mem_addr);
        end
        mem_ack = 1; mem_rdata = 32'h0BADF00D;
        tick();
        mem_ack = 0; mem_rdata = 0;
        #1;
        vec_cnt++;
        if (rdata_MEM !== 32'h0BADF00D || stall_MEM !== 1'b0) begin
            err_cnt++;
            $display("FAIL rstmid_done rdata=%h smem=%b want 0badf00d 0", rdata_MEM, stall_MEM);
        end
        memRead_MEM = 0; pipeAdv = 1;
        tick();
        pipeAdv = 0;
    endtask

    task automatic test_timeout();
        memRead_MEM = 1; addr_MEM = 32'h400;
`ifdef MEM_ARB_TIMEOUT_EN
        repeat (8) tick();
        vec_cnt++;
        if (timeout_err !== 1'b0 || mem_req !== 1'b1) begin
            err_cnt++;
            $display("FAIL tmo_early err=%b req=%b want 0 1", timeout_err, mem_req);
        end
        tick();
        vec_cnt++;
        if (timeout_err !== 1'b1 || rdata_MEM !== 32'hDEADDEAD || stall_MEM !== 1'b0 ||
            mem_req !== 1'b0) begin
            err_cnt++;
            $display("FAIL tmo_fire err=%b rdata=%h smem=%b req=%b want 1 deaddead 0 0",
                     timeout_err, rdata_MEM, stall_MEM, mem_req);
        end
`else
        repeat (20) tick();
        vec_cnt++;
        if (timeout_err !== 1'b0 || mem_req !== 1'b1 || stall_MEM !== 1'b1) begin
            err_cnt++;
            $display("FAIL notmo_wait err=%b req=%b smem=%b want 0 1 1",
                     timeout_err, mem_req, stall_MEM);
        end
        mem_ack = 1; mem_rdata = 32'h00C0FFEE;
        tick();
        mem_ack = 0; mem_rdata = 0;
        #1;
        vec_cnt++;
        if (rdata_MEM !== 32'h00C0FFEE || stall_MEM !== 1'b0) begin
            err_cnt++;
            $display("FAIL notmo_done rdata=%h smem=%b want 00c0ffee 0", rdata_MEM, stall_MEM);
        end
`endif
        memRead_MEM = 0; pipeAdv = 1;
        tick();
        pipeAdv = 0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_contention();
        test_store();
        test_squash();
        test_reset_mid();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
